spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised successor to the team's fixed 8-bit, mode-fixed SPI transmitter: full-duplex SPI master with configurable word width, SCLK divider, CPOL/CPHA mode, bit order and an active-low chip select.
- Runs entirely in the system clock domain. SCLK is a registered output toggled by a divider counter, not a derived clock.
- Sits between the processor-side register interface and an external SPI peripheral (OLED/DAC class devices).

Parameters:
- DATA_WIDTH, 8, bits per transfer (legal range ≥2).
- CLK_DIV, 5, system clocks per SCLK half-period (≥1). 100 MHz with CLK_DIV=5 gives 10 MHz SCLK.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- data_in  in  DATA_WIDTH  word to transmit, latched on accept
- load_data  in  1  start request, level-sampled in IDLE
- busy  out  1  transfer in progress
- done_send  out  1  one-cycle pulse at end of transfer
- data_out  out  DATA_WIDTH  received word, valid from done_send onward
- spi_clock  out  1  SCLK
- spi_data  out  1  MOSI
- spi_miso  in  1  MISO
- spi_cs_n  out  1  active-low chip select

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, busy=0, done_send=0, data_out=0, spi_clock=CPOL, spi_data=0, spi_cs_n=1, counters=0. A reset during a transfer aborts it with no done_send.
- States: IDLE, XFER, TRAIL.
- IDLE:
  - load_data=1 at clock edge E0 accepts the request.
  - At E0: latch data_in into the shift register, busy=1, spi_cs_n=0, spi_data=first bit (data_in[DATA_WIDTH-1] if MSB_FIRST, else data_in[0]). Next state is XFER.
  - load_data while busy=1 is ignored.
- XFER:
  - Divider counts 0..CLK_DIV-1. On wrap, spi_clock toggles. This is SCLK edge k, where k=1..2*DATA_WIDTH, at E0+k*CLK_DIV.
  - Edge k is a sample edge when (k odd) XOR CPHA. On a sample edge, spi_miso is captured into the receive shift register at that same clock edge (MSB-first or LSB-first insertion per MSB_FIRST).
  - All other edges are shift edges: the next bit is presented on spi_data.
  - Exceptions: no shift on k=1 when CPHA=1 (first bit is already presented), and no shift on k=2*DATA_WIDTH when CPHA=0.
  - After edge 2*DATA_WIDTH, spi_clock is back at CPOL and the state moves to TRAIL.
- TRAIL:
  - Wait CLK_DIV clocks.
  - At E0+(2*DATA_WIDTH+1)*CLK_DIV, in a single cycle: spi_cs_n=1, spi_data=0, busy=0, done_send=1, data_out=receive register. State returns to IDLE.
- Latency: accept edge to done_send edge = (2*DATA_WIDTH+1)*CLK_DIV clocks. DATA_WIDTH=8, CLK_DIV=5 gives 85.
- Back-to-back: load_data held high during done_send is accepted on the next edge, so spi_cs_n is high for exactly one cycle between words.
- done_send is a single-cycle pulse, independent of load_data level.
- data_out holds its value until the next done_send or reset.
- CLK_DIV=1: spi_clock toggles every cycle. All rules above are unchanged.
- spi_clock, spi_data and spi_cs_n are driven directly from flops (glitch-free).
- Divider and bit counter widths: $clog2 of their ranges, no overflow. The divider resets to 0 at accept.

Test Plan:
- Mode 0, W=8, DIV=5, loopback spi_miso=spi_data, data_in=0xA5, single load_data pulse:
  - Required: spi_cs_n low for 85 cycles, 8 rising SCLK edges, MOSI bit sequence 1,0,1,0,0,1,0,1.
  - done_send pulses at cycle 85 with data_out=0xA5, busy=0 afterwards.
- Mode 3 (CPOL=1, CPHA=1), W=8, slave model returns 0x3C:
  - Required: spi_clock idles 1, MOSI changes only on falling edges, data_out=0x3C.
- MSB_FIRST=0, W=16, DIV=2, data_in=0x8001, miso tied 1:
  - Required: MOSI sequence starts 1,0…0 and ends 1; data_out=0xFFFF; latency 66 cycles.
- load_data pulsed at cycle 20 of a transfer:
  - Required: ignored, exactly one done_send.
- load_data held high across two words:
  - Required: spi_cs_n high exactly 1 cycle between words, two done_send pulses 86 cycles apart (DIV=5, W=8).
- reset asserted at cycle 40 of a transfer:
  - Required: same-cycle spi_cs_n=1, spi_clock=CPOL, busy=0, no done_send.
  - A fresh transfer after reset release completes normally.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param
//   Full-duplex SPI master with a configurable word width, SCLK divider,
//   CPOL/CPHA mode, bit order and an active-low chip select. Everything runs
//   in the system clock domain. SCLK, MOSI and CS_N come straight from flops.
//
// Parameters
//   DATA_WIDTH  bits per transfer (>= 2)
//   CLK_DIV     system clocks per SCLK half-period (>= 1)
//   CPOL        SCLK idle level
//   CPHA        0: sample on the leading edge, 1: sample on the trailing edge
//   MSB_FIRST   1: MSB shifted first, 0: LSB shifted first
//
// Ports
//   clock      system clock
//   reset      asynchronous, active-high reset
//   data_in    word to transmit, latched when a request is accepted
//   load_data  start request, level-sampled while idle
//   busy       transfer in progress
//   done_send  one-cycle pulse at the end of a transfer
//   data_out   received word, valid from done_send until the next one
//   spi_clock  SCLK
//   spi_data   MOSI
//   spi_miso   MISO
//   spi_cs_n   active-low chip select

module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 5,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load_data,
  output logic                  busy,
  output logic                  done_send,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  spi_clock,
  output logic                  spi_data,
  input  logic                  spi_miso,
  output logic                  spi_cs_n
);

  localparam logic POL = (CPOL != 0);
  localparam logic PHA = (CPHA != 0);
  localparam logic MSB = (MSB_FIRST != 0);

  // Divider counts 0..CLK_DIV-1; keep at least one bit when CLK_DIV is 1.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Edge counter holds the number of SCLK edges produced so far: 0..2*DATA_WIDTH.
  localparam int EDGES  = 2 * DATA_WIDTH;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER  = 2'd1;
  localparam logic [1:0] TRAIL = 2'd2;

  logic [1:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;

  // Decoded control
  logic                  accept;
  logic                  div_wrap;
  logic                  sclk_edge;
  logic                  finish;
  logic [EDGE_W-1:0]     edge_k;
  logic                  sample_edge;
  logic                  last_edge;
  logic                  shift_edge;

  // Data path helpers
  logic                  first_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] tx_rot;
  logic [DATA_WIDTH-1:0] rx_ins;

  always_comb begin
    accept    = (state == IDLE) && load_data;
    div_wrap  = (div_cnt == DIV_LAST);
    sclk_edge = (state == XFER) && div_wrap;
    finish    = (state == TRAIL) && div_wrap;

    // edge_k is the number of the SCLK edge produced on this divider wrap.
    edge_k      = edge_cnt + EDGE_ONE;
    sample_edge = edge_k[0] ^ PHA;
    last_edge   = (edge_k == EDGE_LAST);

    // The first bit is already on MOSI before edge 1, and nothing follows the
    // final bit, so exactly DATA_WIDTH-1 shifts happen in either phase.
    shift_edge = !sample_edge
               && !(PHA && (edge_k == EDGE_ONE))
               && !(!PHA && last_edge);
  end

  // The transmit register rotates rather than shifts so every stored bit
  // stays observable; the bit after the rotation is the next one to present.
  always_comb begin
    if (MSB) begin
      first_bit = data_in[DATA_WIDTH-1];
      tx_rot    = {tx_sr[DATA_WIDTH-2:0], tx_sr[DATA_WIDTH-1]};
      next_bit  = tx_rot[DATA_WIDTH-1];
      rx_ins    = {rx_sr[DATA_WIDTH-2:0], spi_miso};
    end else begin
      first_bit = data_in[0];
      tx_rot    = {tx_sr[0], tx_sr[DATA_WIDTH-1:1]};
      next_bit  = tx_rot[0];
      rx_ins    = {spi_miso, rx_sr[DATA_WIDTH-1:1]};
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= XFER;
          end
        end
        XFER: begin
          if (sclk_edge && last_edge) begin
            state <= TRAIL;
          end
        end
        TRAIL: begin
          if (finish) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Divider and SCLK edge counter. The divider restarts at accept so edge k
  // lands exactly k*CLK_DIV clocks after the accepting edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (accept) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (state != IDLE) begin
      if (div_wrap) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (sclk_edge) begin
        edge_cnt <= edge_k;
      end else if (finish) begin
        edge_cnt <= '0;
      end
    end
  end

  // Transmit and receive shift registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_sr <= '0;
      rx_sr <= '0;
    end else if (accept) begin
      tx_sr <= data_in;
      rx_sr <= '0;
    end else if (sclk_edge) begin
      if (sample_edge) begin
        rx_sr <= rx_ins;
      end
      if (shift_edge) begin
        tx_sr <= tx_rot;
      end
    end
  end

  // SPI pins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spi_clock <= POL;
      spi_data  <= 1'b0;
      spi_cs_n  <= 1'b1;
    end else if (accept) begin
      spi_clock <= POL;
      spi_data  <= first_bit;
      spi_cs_n  <= 1'b0;
    end else if (sclk_edge) begin
      spi_clock <= ~spi_clock;
      if (shift_edge) begin
        spi_data <= next_bit;
      end
    end else if (finish) begin
      spi_data <= 1'b0;
      spi_cs_n <= 1'b1;
    end
  end

  // Processor-side status and result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done_send <= 1'b0;
      data_out  <= '0;
    end else begin
      done_send <= 1'b0;
      if (accept) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy      <= 1'b0;
        done_send <= 1'b1;
        data_out  <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param
//   Runs five differently configured masters side by side. Each one has a
//   driver that issues transfers and an SPI slave/monitor that watches the
//   pins the way a real peripheral would (edge direction and idle level),
//   returns a chosen word on MISO (or loops MOSI back) and checks the result
//   of every transfer when done_send pulses.

module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cfg_w(input int i);
    case (i)
      0, 1:    return 8;
      2:       return 16;
      3:       return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int cfg_div(input int i);
    case (i)
      0, 1:    return 5;
      2:       return 2;
      3:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_pol(input int i);
    return (i == 1 || i == 4) ? 1 : 0;
  endfunction

  function automatic int cfg_pha(input int i);
    return (i == 1 || i == 3) ? 1 : 0;
  endfunction

  function automatic int cfg_msb(input int i);
    return (i == 2 || i == 4) ? 0 : 1;
  endfunction

  for (genvar g = 0; g < 5; g++) begin : gc
    localparam int   W = cfg_w(g);
    localparam int   D = cfg_div(g);
    localparam logic P = (cfg_pol(g) != 0);
    localparam logic H = (cfg_pha(g) != 0);
    localparam logic M = (cfg_msb(g) != 0);
    localparam int   L = (2 * W + 1) * D;

    logic         rst;
    logic         ld;
    logic         busy;
    logic         done;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic         csn;
    logic         loop;
    logic         sbit;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         fin = 1'b0;
    logic         want_gap;

    // Expected transfers, written by the driver, consumed by the monitor.
    logic [W-1:0] a_tx [32];
    logic [W-1:0] a_rx [32];
    logic         a_lb [32];
    int unsigned  n_push;
    int unsigned  n_exp;
    int unsigned  n_done;

    assign miso = loop ? mosi : sbit;

    spi_master_param #(
      .DATA_WIDTH(W),
      .CLK_DIV   (D),
      .CPOL      (cfg_pol(g)),
      .CPHA      (cfg_pha(g)),
      .MSB_FIRST (cfg_msb(g))
    ) u_dut (
      .clock    (clk),
      .reset    (rst),
      .data_in  (din),
      .load_data(ld),
      .busy     (busy),
      .done_send(done),
      .data_out (dout),
      .spi_clock(sclk),
      .spi_data (mosi),
      .spi_miso (miso),
      .spi_cs_n (csn)
    );

    // i-th bit on the wire for word w
    function automatic logic bit_of(input logic [W-1:0] w, input int unsigned i);
      return M ? w[W-1-i] : w[i];
    endfunction

    // ---------------- slave / monitor ----------------
    logic         p_sclk, p_mosi, p_csn, p_done, act;
    logic         lead, samp, chg;
    int unsigned  t_fall, t_rise, n_edge, n_rise, j, viol, n_pop;
    logic [W-1:0] acc, cur_tx, cur_rx;
    logic         cur_lb;

    initial begin
      n_pop  = 0;
      n_done = 0;
      act    = 1'b0;
      sbit   = 1'b0;
      p_csn  = 1'b1;
      p_done = 1'b0;
      t_rise = 0;
    end

    always @(negedge clk) begin
      if (rst) begin
        act    = 1'b0;
        p_csn  = 1'b1;
        p_sclk = sclk;
        p_mosi = mosi;
        p_done = 1'b0;
        sbit   = 1'b0;
        t_rise = cyc;
      end else begin
        if (p_csn && !csn) begin
          if (want_gap) check_eq($sformatf("c%0d_cs_gap", g), cyc - t_rise, 1);
          check_eq($sformatf("c%0d_start_expected", g), 32'(n_pop < n_push), 1);
          if (n_pop < n_push) begin
            cur_tx = a_tx[n_pop];
            cur_rx = a_rx[n_pop];
            cur_lb = a_lb[n_pop];
          end
          n_pop++;
          act    = 1'b1;
          t_fall = cyc;
          n_edge = 0;
          n_rise = 0;
          j      = 0;
          viol   = 0;
          acc    = '0;
          sbit   = bit_of(cur_rx, 0);
        end else if (act && !csn) begin
          chg  = (sclk != p_sclk);
          lead = (sclk != P);
          samp = chg && (lead != H);
          if (chg) begin
            n_edge++;
            if (sclk) n_rise++;
          end
          if (samp) begin
            if (j < W) begin
              if (M) acc[W-1-j] = mosi;
              else   acc[j]     = mosi;
            end
            j++;
            sbit = (j < W) ? bit_of(cur_rx, j) : 1'b0;
          end
          // MOSI may only move on a shift edge
          if ((mosi != p_mosi) && !(chg && !samp)) viol++;
        end

        if (!p_csn && csn) begin
          check_eq($sformatf("c%0d_cs_rise_with_done", g), 32'(done), 1);
          act    = 1'b0;
          t_rise = cyc;
        end

        if (done) begin
          n_done++;
          check_eq($sformatf("c%0d_done_width", g), 32'(p_done), 0);
          check_eq($sformatf("c%0d_latency", g), cyc - t_fall, L);
          check_eq($sformatf("c%0d_sclk_edges", g), n_edge, 2 * W);
          check_eq($sformatf("c%0d_sclk_rises", g), n_rise, W);
          check_eq($sformatf("c%0d_mosi_word", g), 32'(acc), 32'(cur_tx));
          check_eq($sformatf("c%0d_data_out", g), 32'(dout), 32'(cur_lb ? cur_tx : cur_rx));
          check_eq($sformatf("c%0d_mosi_timing", g), viol, 0);
          check_eq($sformatf("c%0d_end_pins", g), {29'd0, busy, sclk, mosi}, {29'd0, 1'b0, P, 1'b0});
        end

        p_sclk = sclk;
        p_mosi = mosi;
        p_csn  = csn;
        p_done = done;
      end
    end

    // ---------------- driver ----------------
    task automatic push(input logic [W-1:0] tx, input logic [W-1:0] rx, input logic lb);
      if (n_push < 32) begin
        a_tx[n_push] = tx;
        a_rx[n_push] = rx;
        a_lb[n_push] = lb;
        n_push++;
        n_exp++;
      end
    endtask

    task automatic wait_idle();
      int unsigned t = 0;
      while ((busy || !csn) && t < 4 * L + 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 4 * L + 100) check_eq($sformatf("c%0d_idle_timeout", g), {csn, busy}, 2'b10);
    endtask

    task automatic wait_done();
      int unsigned t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!done && t < 4 * L + 100);
      if (!done) check_eq($sformatf("c%0d_done_timeout", g), 32'(done), 1);
    endtask

    task automatic xfer(input logic [W-1:0] tx, input logic [W-1:0] rx, input logic lb);
      wait_idle();
      din  = tx;
      loop = lb;
      push(tx, rx, lb);
      ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
    endtask

    initial begin
      logic [W-1:0] w1, w2;
      int unsigned  t1;
      rst      = 1'b1;
      ld       = 1'b0;
      din      = '0;
      loop     = 1'b0;
      want_gap = 1'b0;
      n_push   = 0;
      n_exp    = 0;
      repeat (2) @(negedge clk);
      check_eq($sformatf("c%0d_rst_pins", g), {28'd0, csn, sclk, mosi, busy}, {28'd0, 1'b1, P, 1'b0, 1'b0});
      check_eq($sformatf("c%0d_rst_done", g), 32'(done), 0);
      check_eq($sformatf("c%0d_rst_dout", g), 32'(dout), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      if (g == 0) begin
        // loopback of 0xA5
        xfer(W'(8'hA5), '0, 1'b1);
        // request mid-transfer is ignored
        xfer(W'($urandom), W'($urandom), 1'b0);
        repeat (19) @(negedge clk);
        din = ~din;
        ld  = 1'b1;
        @(negedge clk);
        ld  = 1'b0;
        wait_idle();
        repeat (L) @(negedge clk);
        check_eq("c0_single_done", n_done, n_exp);
        // load_data held across two words
        w1 = W'($urandom);
        w2 = W'($urandom);
        din  = w1;
        loop = 1'b0;
        push(w1, ~w1, 1'b0);
        ld = 1'b1;
        @(negedge clk);
        wait_done();
        t1 = cyc;
        din = w2;
        push(w2, w1, 1'b0);
        want_gap = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_done();
        check_eq("c0_b2b_spacing", cyc - t1, L + 1);
        want_gap = 1'b0;
        // reset in the middle of a transfer
        xfer(W'($urandom), W'($urandom), 1'b0);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("c0_abort_pins", {29'd0, csn, sclk, busy}, {29'd0, 1'b1, P, 1'b0});
        check_eq("c0_abort_done", 32'(done), 0);
        n_exp--;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(W'($urandom), W'($urandom), 1'b0);
      end else if (g == 1) begin
        xfer(W'($urandom), W'(8'h3C), 1'b0);
      end else if (g == 2) begin
        xfer(W'(16'h8001), '1, 1'b0);
      end

      repeat (6) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        xfer(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end

      wait_idle();
      repeat (L + 20) @(negedge clk);
      check_eq($sformatf("c%0d_done_count", g), n_done, n_exp);
      fin = 1'b1;
    end
  end

  initial begin
    int unsigned t = 0;
    while (!(gc[0].fin && gc[1].fin && gc[2].fin && gc[3].fin && gc[4].fin) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    check_eq("all_configs_finished",
             {27'd0, gc[4].fin, gc[3].fin, gc[2].fin, gc[1].fin, gc[0].fin}, 32'h1f);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
